// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, memory op codes and lane-steering helpers
// for the memory-access stage.
//   DATA_W / REG_W : data and register-address widths
//   ZERO_WORD      : all-zero data word
//   mem_op_e       : MEM_NOP and the load/store op codes carried on memop_i
//   mem_req_t      : per-transaction state latched when a bus access starts
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic {ST_IDLE, ST_BUS} mem_state_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [REG_W-1:0] waddr;
    logic [1:0]       off;    // byte offset after alignment forcing
    logic             flush;  // flush seen at entry or while waiting
  } mem_req_t;

  function automatic logic is_load(logic [3:0] op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic is_half(logic [3:0] op);
    return op inside {MEM_LH, MEM_LHU, MEM_SH};
  endfunction

  function automatic logic is_word(logic [3:0] op);
    return op inside {MEM_LW, MEM_SW};
  endfunction

  // Low address bits that are meaningless for the access size are dropped.
  function automatic logic [1:0] align_off(logic [3:0] op, logic [1:0] off);
    if (is_word(op))      return 2'b00;
    else if (is_half(op)) return {off[1], 1'b0};
    else                  return off;
  endfunction

  function automatic logic misaligned(logic [3:0] op, logic [1:0] off);
    return (is_half(op) & off[0]) | (is_word(op) & (off != 2'b00));
  endfunction

  // Big-endian lanes: offset 0 is lane 3 (bits 31:24).
  function automatic logic [3:0] lane_sel(logic [3:0] op, logic [1:0] off);
    if (is_word(op))      return 4'b1111;
    else if (is_half(op)) return off[1] ? 4'b0011 : 4'b1100;
    else                  return 4'b1000 >> off;
  endfunction

  // Store data is replicated into every lane; bus_sel picks the live one.
  function automatic logic [DATA_W-1:0] store_rep(logic [3:0] op, logic [DATA_W-1:0] d);
    if (is_word(op))      return d;
    else if (is_half(op)) return {2{d[15:0]}};
    else                  return {4{d[7:0]}};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: single-outstanding req/ack data bus.
//   req/we/addr/sel/wdata : request, held stable by the master until ack
//   ack/rdata             : response from the slave
// Modports: master (mem_stage side), slave (memory side).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [3:0]        sel;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half out of a big-endian bus
// word and sign- or zero-extends it to 32 bits.
//   op    : load op code (mem_op_e)
//   off   : byte offset within the word (already aligned for halves/words)
//   rdata : raw bus read data
//   ldata : extended load value
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ldata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    case (off)
      2'd0: b = rdata[31:24];
      2'd1: b = rdata[23:16];
      2'd2: b = rdata[15:8];
      2'd3: b = rdata[7:0];
      default: b = 8'h00;
    endcase
    h = off[1] ? rdata[15:0] : rdata[31:16];

    ldata = rdata;
    case (op)
      MEM_LB:  ldata = {{24{b[7]}}, b};
      MEM_LBU: ldata = {24'h0, b};
      MEM_LH:  ldata = {{16{h[15]}}, h};
      MEM_LHU: ldata = {16'h0, h};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage and MEM/WB register.
// Non-memory ops are registered straight through; loads/stores run one
// req/ack bus transaction while stall_req_o holds upstream.
// Optional macro MEM_ALIGN_CHECK_EN: trap misaligned accesses (adel_o/ades_o)
// instead of silently forcing alignment.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   valid_i, wdata_i, waddr_i,
//   we_i, memop_i, maddr_i,
//   sdata_i, flush_i             : execute-stage outputs
//   stall_req_o                  : hold upstream this cycle
//   dbus                         : data bus (master)
//   wdata_o, waddr_o, we_o       : registered write-back
//   adel_o, ades_o               : misalignment flags (MEM_ALIGN_CHECK_EN only)
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  waddr_i,
  input  logic              we_i,
  input  logic [3:0]        memop_i,
  input  logic [DATA_W-1:0] maddr_i,
  input  logic [DATA_W-1:0] sdata_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  mem_stage_if.master       dbus,
  output logic [DATA_W-1:0] wdata_o,
  output logic [REG_W-1:0]  waddr_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              adel_o,
  output logic              ades_o,
`endif
  output logic              we_o
);

  mem_state_e        state;
  mem_req_t          req_q;
  logic [DATA_W-1:0] ldata;
  logic              is_mem;
  logic              mis;

  always_comb begin
    is_mem = valid_i & (is_load(memop_i) | is_store(memop_i));
`ifdef MEM_ALIGN_CHECK_EN
    mis = misaligned(memop_i, maddr_i[1:0]);
`else
    mis = 1'b0;
`endif
  end

  // A trapped misaligned op writes back immediately, so it never stalls.
  assign stall_req_o = ((state == ST_IDLE) & is_mem & ~mis) |
                       ((state == ST_BUS) & ~dbus.ack);

  mem_load_align u_align (
    .op    (req_q.op),
    .off   (req_q.off),
    .rdata (dbus.rdata),
    .ldata (ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      dbus.req   <= 1'b0;
      dbus.we    <= 1'b0;
      dbus.addr  <= ZERO_WORD;
      dbus.sel   <= 4'b0000;
      dbus.wdata <= ZERO_WORD;
      wdata_o    <= ZERO_WORD;
      waddr_o    <= '0;
      we_o       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem && !mis) begin
            // A flush arriving with the op still lets the access run (it
            // cannot be withdrawn once issued); it only kills write-back.
            req_q      <= '{op: memop_i, waddr: waddr_i,
                            off: align_off(memop_i, maddr_i[1:0]), flush: flush_i};
            dbus.req   <= 1'b1;
            dbus.we    <= is_store(memop_i);
            dbus.addr  <= {maddr_i[DATA_W-1:2], 2'b00};
            dbus.sel   <= lane_sel(memop_i, maddr_i[1:0]);
            dbus.wdata <= store_rep(memop_i, sdata_i);
            we_o       <= 1'b0;
            state      <= ST_BUS;
          end else begin
            // Pass-through; a trapped memory op lands here with we_o=0.
            wdata_o <= wdata_i;
            waddr_o <= waddr_i;
            we_o    <= we_i & valid_i & ~flush_i & ~is_mem;
          end
        end
        ST_BUS: begin
          req_q.flush <= req_q.flush | flush_i;
          if (dbus.ack) begin
            dbus.req <= 1'b0;
            dbus.we  <= 1'b0;
            waddr_o  <= req_q.waddr;
            we_o     <= is_load(req_q.op) & ~(req_q.flush | flush_i);
            if (is_load(req_q.op)) wdata_o <= ldata;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Flags follow every IDLE-cycle write-back and clear on bus completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      adel_o <= 1'b0;
      ades_o <= 1'b0;
    end else if (state == ST_IDLE) begin
      adel_o <= is_mem & mis & is_load(memop_i);
      ades_o <= is_mem & mis & is_store(memop_i);
    end else if (dbus.ack) begin
      adel_o <= 1'b0;
      ades_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage with hand-computed results.
// Inputs change 1 time unit after the rising edge; registered outputs are
// read there and stall_req_o one unit later, once the new inputs settle.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i, we_i, flush_i;
  logic [DATA_W-1:0] wdata_i, maddr_i, sdata_i;
  logic [REG_W-1:0]  waddr_i;
  logic [3:0]        memop_i;
  logic              stall_req_o, we_o;
  logic [DATA_W-1:0] wdata_o;
  logic [REG_W-1:0]  waddr_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic              adel_o, ades_o;
`endif

  mem_stage_if dbus ();

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .wdata_i     (wdata_i),
    .waddr_i     (waddr_i),
    .we_i        (we_i),
    .memop_i     (memop_i),
    .maddr_i     (maddr_i),
    .sdata_i     (sdata_i),
    .flush_i     (flush_i),
    .stall_req_o (stall_req_o),
    .dbus        (dbus.master),
    .wdata_o     (wdata_o),
    .waddr_o     (waddr_o),
`ifdef MEM_ALIGN_CHECK_EN
    .adel_o      (adel_o),
    .ades_o      (ades_o),
`endif
    .we_o        (we_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one memory op, ack it after 'waits' idle bus cycles, and capture
  // the bus request as seen in the first BUS cycle.
  task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr, sd, rd,
                         input int waits, output int stalls,
                         output logic [31:0] c_addr, c_wdata,
                         output logic [3:0] c_sel, output logic c_req, c_we);
    memop_i = op; maddr_i = addr; sdata_i = sd;
    valid_i = 1'b1; we_i = 1'b1; waddr_i = 5'd7;
    stalls = 0;
    c_addr = '0; c_wdata = '0; c_sel = '0; c_req = 1'b0; c_we = 1'b0;
    for (int c = 0; c <= waits + 1; c++) begin
      if (c == waits + 1) begin
        dbus.ack = 1'b1;
        dbus.rdata = rd;
      end
      #1;
      if (stall_req_o) stalls++;
      if (c == 1) begin
        c_addr = dbus.addr; c_wdata = dbus.wdata; c_sel = dbus.sel;
        c_req = dbus.req; c_we = dbus.we;
      end
      tick;
    end
    dbus.ack = 1'b0;
    valid_i = 1'b0;
    memop_i = MEM_NOP;
  endtask

  int          st;
  logic [31:0] ca, cw;
  logic [3:0]  cs;
  logic        cr, cwe;

  initial begin
    rst = 1'b1; valid_i = 1'b0; we_i = 1'b0; flush_i = 1'b0;
    wdata_i = '0; maddr_i = '0; sdata_i = '0; waddr_i = '0; memop_i = MEM_NOP;
    dbus.ack = 1'b0; dbus.rdata = '0;
    tick; tick;

    // Reset state
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_waddr", {27'h0, waddr_o}, 32'h0);
    chk("rst_we", {31'h0, we_o}, 32'h0);
    chk("rst_bus", {dbus.req, dbus.we, dbus.sel, dbus.addr[25:0]}, 32'h0);
    chk("rst_bwdata", dbus.wdata, 32'h0);
    rst = 1'b0;

    // ALU pass-through
    valid_i = 1'b1; memop_i = MEM_NOP; wdata_i = 32'h1234ABCD; waddr_i = 5'd5; we_i = 1'b1;
    #1 chk("alu_stall", {31'h0, stall_req_o}, 32'h0);
    tick;
    chk("alu_wdata", wdata_o, 32'h1234ABCD);
    chk("alu_waddr", {27'h0, waddr_o}, 32'd5);
    chk("alu_we", {31'h0, we_o}, 32'd1);
    valid_i = 1'b0; wdata_i = '0;
    tick;
    chk("alu_we_drop", {31'h0, we_o}, 32'd0);

    // LB at 0x101, 3 wait cycles
    mem_txn(MEM_LB, 32'h101, 32'h0, 32'h11F03344, 3, st, ca, cw, cs, cr, cwe);
    chk("lb_addr", ca, 32'h100);
    chk("lb_sel", {28'h0, cs}, 32'b0100);
    chk("lb_req_we", {30'h0, cr, cwe}, 32'b10);
    chk("lb_stalls", st, 32'd4);
    chk("lb_wdata", wdata_o, 32'hFFFFFFF0);
    chk("lb_we", {31'h0, we_o}, 32'd1);
    chk("lb_waddr", {27'h0, waddr_o}, 32'd7);
    chk("lb_req_drop", {31'h0, dbus.req}, 32'd0);

    // SH at 0x202, zero-wait ack
    mem_txn(MEM_SH, 32'h202, 32'h0000BEEF, 32'h0, 0, st, ca, cw, cs, cr, cwe);
    chk("sh_we_bus", {31'h0, cwe}, 32'd1);
    chk("sh_sel", {28'h0, cs}, 32'b0011);
    chk("sh_wdata", cw, 32'hBEEFBEEF);
    chk("sh_addr", ca, 32'h200);
    chk("sh_stalls", st, 32'd1);
    chk("sh_we", {31'h0, we_o}, 32'd0);

    // LHU zero-extension, offset 0
    mem_txn(MEM_LHU, 32'h100, 32'h0, 32'h80012222, 0, st, ca, cw, cs, cr, cwe);
    chk("lhu_sel", {28'h0, cs}, 32'b1100);
    chk("lhu_wdata", wdata_o, 32'h00008001);

    // LH sign-extension, offset 2, one wait cycle
    mem_txn(MEM_LH, 32'h102, 32'h0, 32'h1234F00F, 1, st, ca, cw, cs, cr, cwe);
    chk("lh_stalls", st, 32'd2);
    chk("lh_wdata", wdata_o, 32'hFFFFF00F);

    // SB at offset 3
    mem_txn(MEM_SB, 32'h003, 32'h00000012, 32'h0, 0, st, ca, cw, cs, cr, cwe);
    chk("sb_sel", {28'h0, cs}, 32'b0001);
    chk("sb_wdata", cw, 32'h12121212);

    // Flush while waiting on an LW
    memop_i = MEM_LW; maddr_i = 32'h300; valid_i = 1'b1; waddr_i = 5'd9;
    tick;
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0; dbus.ack = 1'b1; dbus.rdata = 32'hCAFEF00D;
    #1 chk("fl_req_held", {31'h0, dbus.req}, 32'd1);
    tick;
    dbus.ack = 1'b0; valid_i = 1'b0; memop_i = MEM_NOP;
    chk("fl_we", {31'h0, we_o}, 32'd0);
    chk("fl_req_drop", {31'h0, dbus.req}, 32'd0);

    // Reset mid-BUS, then a stray ack
    memop_i = MEM_LW; maddr_i = 32'h400; valid_i = 1'b1;
    tick;
    chk("rb_req", {31'h0, dbus.req}, 32'd1);
    rst = 1'b1; valid_i = 1'b0; memop_i = MEM_NOP;
    tick;
    rst = 1'b0;
    chk("rb_req_off", {31'h0, dbus.req}, 32'd0);
    chk("rb_bus", {dbus.sel, dbus.addr[27:0]}, 32'h0);
    chk("rb_wb", {we_o, wdata_o[30:0]}, 32'h0);
    dbus.ack = 1'b1; dbus.rdata = 32'hDEADBEEF;
    tick;
    dbus.ack = 1'b0;
    chk("rb_ack_we", {31'h0, we_o}, 32'd0);
    chk("rb_ack_wdata", wdata_o, 32'h0);
    chk("rb_ack_req", {31'h0, dbus.req}, 32'd0);

    // Misaligned LW at 0x3
`ifdef MEM_ALIGN_CHECK_EN
    memop_i = MEM_LW; maddr_i = 32'h3; valid_i = 1'b1;
    #1 chk("mis_stall", {31'h0, stall_req_o}, 32'd0);
    tick;
    valid_i = 1'b0; memop_i = MEM_NOP;
    chk("mis_adel", {31'h0, adel_o}, 32'd1);
    chk("mis_we", {31'h0, we_o}, 32'd0);
    chk("mis_req", {31'h0, dbus.req}, 32'd0);
    tick;
    chk("mis_adel_clr", {31'h0, adel_o}, 32'd0);
`else
    mem_txn(MEM_LW, 32'h3, 32'h0, 32'hA5A5A5A5, 0, st, ca, cw, cs, cr, cwe);
    chk("mis_addr", ca, 32'h0);
    chk("mis_sel", {28'h0, cs}, 32'hF);
    chk("mis_stalls", st, 32'd1);
    chk("mis_wdata", wdata_o, 32'hA5A5A5A5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
